// File: rtl/dpd_delay_est.sv
`default_nettype none
// ============================================================================
// dpd_delay_est : sign-correlation loop-delay estimator for the DPD feedback path
// Rev 1.0
// ============================================================================
module dpd_delay_est #(
   parameter  int W       = 20,
   parameter  int MAX_LAG = 1024,
   parameter  int WIN     = 4096,
   parameter  int THRESH  = 6144,
   localparam int LW      = $clog2(MAX_LAG),
   localparam int SW      = $clog2(2*WIN+1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [W-1:0]  sig_ref_i,
   input  logic [W-1:0]  sig_ref_q,
   input  logic [W-1:0]  sig_fb_i,
   input  logic [W-1:0]  sig_fb_q,
   output logic          busy,
   output logic          done,
   output logic [LW-1:0] delay,
   output logic [SW-1:0] score,
   output logic          found
);

   localparam int            CW          = $clog2((MAX_LAG > WIN) ? MAX_LAG : WIN);
   localparam logic [CW-1:0] C_FILL_LAST = CW'(MAX_LAG-1);
   localparam logic [CW-1:0] C_ACC_LAST  = CW'(WIN-1);
   localparam logic [LW-1:0] C_LAG_LAST  = LW'(MAX_LAG-1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_FILL = 3'd1,
      S_ACC  = 3'd2,
      S_EVAL = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;

   logic [1:0]              r_s_ref;
   logic [1:0]              r_s_fb;
   logic [2*MAX_LAG-3:0]    r_line;
   logic [2*MAX_LAG-1:0]    w_line;
   logic [1:0]              w_sel;
   logic [1:0]              w_inc;

   logic [CW-1:0]           r_cnt;
   logic [LW-1:0]           r_lag;
   logic [SW-1:0]           r_acc;
   logic [LW-1:0]           r_best_lag;
   logic [SW-1:0]           r_best_score;

   logic                    w_better;
   logic [LW-1:0]           w_fin_lag;
   logic [SW-1:0]           w_fin_score;
   logic                    w_unused_lsbs;

   // Only the sign bits take part in the correlation.
   assign w_unused_lsbs = ^{sig_ref_i[W-2:0], sig_ref_q[W-2:0],
                            sig_fb_i[W-2:0],  sig_fb_q[W-2:0]};

   // Tap 0 is the input register itself; taps 1..MAX_LAG-1 are the shift line.
   assign w_line = {r_line, r_s_ref};
   assign w_sel  = w_line[{r_lag, 1'b0} +: 2];
   assign w_inc  = {1'b0, (r_s_fb[1] == w_sel[1])} + {1'b0, (r_s_fb[0] == w_sel[0])};

   // Strict compare keeps the smallest lag on ties.
   assign w_better    = (r_acc > r_best_score);
   assign w_fin_lag   = w_better ? r_lag : r_best_lag;
   assign w_fin_score = w_better ? r_acc : r_best_score;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (start)                 w_state_nxt = S_FILL;
         S_FILL: if (r_cnt == C_FILL_LAST)  w_state_nxt = S_ACC;
         S_ACC:  if (r_cnt == C_ACC_LAST)   w_state_nxt = S_EVAL;
         S_EVAL: w_state_nxt = (r_lag == C_LAG_LAST) ? S_DONE : S_ACC;
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s_ref      <= '0;
         r_s_fb       <= '0;
         r_line       <= '0;
         r_cnt        <= '0;
         r_lag        <= '0;
         r_acc        <= '0;
         r_best_lag   <= '0;
         r_best_score <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         delay        <= '0;
         score        <= '0;
         found        <= 1'b0;
      end else begin
         r_s_ref <= {sig_ref_i[W-1], sig_ref_q[W-1]};
         r_s_fb  <= {sig_fb_i[W-1],  sig_fb_q[W-1]};
         r_line  <= w_line[2*MAX_LAG-3:0];
         busy    <= (w_state_nxt != S_IDLE);
         done    <= (w_state_nxt == S_DONE);

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cnt        <= '0;
                  r_lag        <= '0;
                  r_best_lag   <= '0;
                  r_best_score <= '0;
               end
            end
            S_FILL: begin
               if (r_cnt == C_FILL_LAST) begin
                  r_cnt <= '0;
                  r_acc <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_ACC: begin
               r_acc <= r_acc + SW'(w_inc);
               r_cnt <= (r_cnt == C_ACC_LAST) ? '0 : r_cnt + CW'(1);
            end
            S_EVAL: begin
               if (w_better) begin
                  r_best_score <= r_acc;
                  r_best_lag   <= r_lag;
               end
               // Results are loaded on entry to DONE so they appear together with done.
               if (r_lag == C_LAG_LAST) begin
                  delay <= w_fin_lag;
                  score <= w_fin_score;
                  found <= (int'(w_fin_score) >= THRESH);
               end else begin
                  r_lag <= r_lag + LW'(1);
                  r_acc <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dpd_delay_est.sv
`default_nettype none
// ============================================================================
// tb_dpd_delay_est : randomized directed bench for dpd_delay_est with a
// window-sum reference model.   Rev 1.0
// ============================================================================
module tb_dpd_delay_est;

   localparam int W      = 20;
   localparam int ML     = 16;
   localparam int WN     = 64;
   localparam int TH     = 96;
   localparam int LW     = 4;
   localparam int SW     = 8;
   localparam int HN     = 16384;
   localparam int SEARCH = ML + ML*(WN+1) + 1;

   logic                clk = 1'b0;
   logic                reset;
   logic                start;
   logic signed [W-1:0] ref_i, ref_q, fb_i, fb_q;
   logic                busy, done, found;
   logic [LW-1:0]       delay;
   logic [SW-1:0]       score;

   int checks   = 0;
   int failures = 0;
   int ecnt     = 0;
   int mode     = 0;
   int dly      = 0;

   logic signed [W-1:0] hv_i [HN];
   logic signed [W-1:0] hv_q [HN];
   logic [1:0]          hr   [HN];
   logic [1:0]          hf   [HN];

   always #5 clk = ~clk;

   dpd_delay_est #(.W(W), .MAX_LAG(ML), .WIN(WN), .THRESH(TH)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .sig_ref_i (ref_i),
      .sig_ref_q (ref_q),
      .sig_fb_i  (fb_i),
      .sig_fb_q  (fb_q),
      .busy      (busy),
      .done      (done),
      .delay     (delay),
      .score     (score),
      .found     (found)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Produce the inputs that the next rising edge (index ecnt) will sample.
   task automatic gen();
      logic signed [W-1:0] ri, rq, fi, fq;
      ri = W'($urandom);
      rq = W'($urandom);
      fi = W'($urandom);
      fq = W'($urandom);
      case (mode)
         1: begin
            fi = (ecnt >= dly) ? hv_i[ecnt-dly] : '0;
            fq = (ecnt >= dly) ? hv_q[ecnt-dly] : '0;
         end
         2: begin
            ri = 20'sd1000; rq = 20'sd1000; fi = 20'sd2000; fq = 20'sd3000;
         end
         3: begin
            fi = (ecnt >= dly) ? -hv_i[ecnt-dly] : '0;
            fq = (ecnt >= dly) ? -hv_q[ecnt-dly] : '0;
         end
         default: begin
         end
      endcase
      if (ecnt < HN) begin
         hv_i[ecnt] = ri;
         hv_q[ecnt] = rq;
      end
      ref_i = ri; ref_q = rq; fb_i = fi; fb_q = fq;
   endtask

   task automatic cycle();
      if (ecnt < HN) begin
         hr[ecnt] = {ref_i[W-1], ref_q[W-1]};
         hf[ecnt] = {fb_i[W-1],  fb_q[W-1]};
      end
      @(posedge clk);
      ecnt++;
      #1;
      gen();
   endtask

   // Score of lag L = agreeing sign bits over its WIN-sample window.
   // Lag L's window starts MAX_LAG + L*(WIN+1) samples after the start sample.
   function automatic void model(input int se, output int bl, output int bs);
      bl = 0;
      bs = 0;
      for (int L = 0; L < ML; L++) begin
         int s;
         int base;
         s    = 0;
         base = se + ML + (WN+1)*L;
         for (int n = base; n < base + WN; n++) begin
            s += ((hf[n][1] == hr[n-L][1]) ? 1 : 0) + ((hf[n][0] == hr[n-L][0]) ? 1 : 0);
         end
         if (s > bs) begin
            bs = s;
            bl = L;
         end
      end
   endfunction

   task automatic do_search(input string tag, input bit extra, input bit hold_chk,
                            input logic [LW-1:0] hold_val);
      int  se, bl, bs;
      bit  ok;
      start = 1'b1;
      se    = ecnt;
      cycle();
      start = 1'b0;
      chk({tag, "_busy_rise"}, busy, 1);
      ok = 1'b0;
      for (int i = 0; i < SEARCH + 100; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (hold_chk && (i == 200 || i == 800))
            chk({tag, "_delay_hold"}, delay, hold_val);
         start = extra && (i == 20 || i == 45);
         cycle();
         start = 1'b0;
      end
      chk({tag, "_done_seen"}, done, 1);
      if (ok) begin
         model(se, bl, bs);
         chk({tag, "_done_time"}, ecnt - 1 - se, SEARCH - 1);
         chk({tag, "_busy_at_done"}, busy, 1);
         chk({tag, "_delay"}, delay, bl);
         chk({tag, "_score"}, score, bs);
         chk({tag, "_found"}, found, (bs >= TH) ? 1 : 0);
         cycle();
         chk({tag, "_busy_fall"}, busy, 0);
         chk({tag, "_done_pulse"}, done, 0);
      end
   endtask

   initial begin
      int dcount;
      reset = 1'b1;
      start = 1'b1;
      mode  = 0;
      dly   = 0;
      gen();
      repeat (4) cycle();
      chk("rst_busy",  busy,  0);
      chk("rst_done",  done,  0);
      chk("rst_delay", delay, 0);
      chk("rst_score", score, 0);
      chk("rst_found", found, 0);
      reset = 1'b0;
      start = 1'b0;
      cycle();
      chk("rst_start_ignored", busy, 0);

      // Pure delay of 5, then back-to-back with the delay switched to 9.
      mode = 1;
      dly  = 5;
      repeat (20) cycle();
      do_search("pure5", 1'b0, 1'b0, '0);
      chk("pure5_spec_delay", delay, 5);
      chk("pure5_spec_score", score, 128);
      chk("pure5_spec_found", found, 1);
      dly = 9;
      do_search("b2b9", 1'b0, 1'b1, 4'd5);
      chk("b2b9_spec_delay", delay, 9);
      chk("b2b9_spec_score", score, 128);

      // Constant positive inputs: every lag ties, smallest wins.
      mode = 2;
      repeat (10) cycle();
      do_search("tie", 1'b0, 1'b0, '0);
      chk("tie_spec_delay", delay, 0);
      chk("tie_spec_score", score, 128);
      chk("tie_spec_found", found, 1);

      // Inverted feedback delayed by 3.
      mode = 3;
      dly  = 3;
      repeat (10) cycle();
      do_search("inv3", 1'b0, 1'b0, '0);
      chk("inv3_score_low", (score < TH) ? 1 : 0, 1);
      chk("inv3_found", found, 0);
      chk("inv3_delay_not3", (delay != 4'd3) ? 1 : 0, 1);

      // Extra start pulses during ACC must not restart the search.
      mode = 1;
      dly  = 7;
      repeat (10) cycle();
      do_search("ignore7", 1'b1, 1'b0, '0);
      chk("ignore7_spec_delay", delay, 7);

      // Reset mid-ACC aborts the search and clears the outputs.
      start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (40) cycle();
      chk("abort_busy_before", busy, 1);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("abort_busy",  busy,  0);
      chk("abort_done",  done,  0);
      chk("abort_delay", delay, 0);
      chk("abort_score", score, 0);
      chk("abort_found", found, 0);
      dcount = 0;
      for (int i = 0; i < SEARCH + 50; i++) begin
         cycle();
         if (done === 1'b1 || busy === 1'b1) dcount++;
      end
      chk("abort_no_done", dcount, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
